// File: rtl/dac_tx_pkg.sv
// Shared definitions for the dac_tx SPI DAC writer: frame layout, phase lengths
// in SCLK half-periods, and the controller state encoding.
package dac_tx_pkg;

  localparam int DATA_W  = 12;
  localparam int FRAME_W = 16;

  localparam int BIT_ZERO   = 15;
  localparam int BIT_BUF    = 14;
  localparam int BIT_GAIN   = 13;
  localparam int BIT_ACTIVE = 12;

  localparam int LEAD_HP  = 2;
  localparam int SHIFT_HP = 2 * FRAME_W;
  localparam int TRAIL_HP = 2;
  localparam int LATCH_HP = 2;
  localparam int QUIET_HP = 2;
  localparam int HALF_W   = $clog2(SHIFT_HP);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    TRAIL = 3'd3,
    LATCH = 3'd4,
    QUIET = 3'd5
  } dacState_t;

  function automatic logic [HALF_W-1:0] lastHalf(dacState_t s);
    logic [HALF_W-1:0] n;
    n = '0;
    case (s)
      LEAD:    n = HALF_W'(LEAD_HP - 1);
      SHIFT:   n = HALF_W'(SHIFT_HP - 1);
      TRAIL:   n = HALF_W'(TRAIL_HP - 1);
      LATCH:   n = HALF_W'(LATCH_HP - 1);
      QUIET:   n = HALF_W'(QUIET_HP - 1);
      default: n = '0;
    endcase
    return n;
  endfunction

  function automatic logic [FRAME_W-1:0] buildFrame(logic bufSel, logic gain1x,
                                                     logic [DATA_W-1:0] code);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[BIT_ZERO]     = 1'b0;
    f[BIT_BUF]      = bufSel;
    f[BIT_GAIN]     = gain1x;
    f[BIT_ACTIVE]   = 1'b1;
    f[DATA_W-1:0]   = code;
    return f;
  endfunction

endpackage

// File: rtl/dac_tx_if.sv
// Write-request handshake plus the four DAC-side SPI lines.
interface dac_tx_if;
  import dac_tx_pkg::*;

  logic              start;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              done;
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              ldac_n;

  modport master (output start, data, input ready, done, sclk, cs_n, mosi, ldac_n);
  modport slave  (input start, data, output ready, done, sclk, cs_n, mosi, ldac_n);

endinterface

// File: rtl/dac_tx_spi_half_tick.sv
// Free-running CLK_DIV divider: tick is high for one clk in every CLK_DIV,
// and restart realigns the count so the first tick lands CLK_DIV cycles later.
module spi_half_tick #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dac_tx.sv
// 16-bit SPI (mode 0) write to a 12-bit DAC with LDAC latch strobe.
// All DAC-side lines are registered so they change cleanly on clk edges.
module dac_tx
  import dac_tx_pkg::*;
#(
  parameter int CLK_DIV = 10,
  parameter bit BUF     = 1'b0,
  parameter bit GAIN_1X = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  dac_tx_if.slave  bus
);

  dacState_t          state, nextState;
  logic [HALF_W-1:0]  halfCnt, nextHalf;
  logic [FRAME_W-1:0] shiftReg, nextShift;
  logic               doneQ, doneNext;
  logic               sclkQ, sclkNext;
  logic               csnQ, csnNext;
  logic               mosiQ, mosiNext;
  logic               ldacnQ, ldacnNext;
  logic               accept;
  logic               tick;

  assign accept = (state == IDLE) && bus.start;

  spi_half_tick #(.CLK_DIV(CLK_DIV)) uHalfTick (
    .clk     (clk),
    .reset   (reset),
    .restart (accept),
    .tick    (tick)
  );

  always_comb begin
    nextState = state;
    nextHalf  = halfCnt;
    nextShift = shiftReg;
    doneNext  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          nextState = LEAD;
          nextHalf  = '0;
          nextShift = buildFrame(BUF, GAIN_1X, bus.data);
        end
      end
      default: begin
        if (tick) begin
          if (halfCnt == lastHalf(state)) begin
            nextHalf = '0;
            case (state)
              LEAD:    nextState = SHIFT;
              SHIFT:   nextState = TRAIL;
              TRAIL:   nextState = LATCH;
              LATCH:   nextState = QUIET;
              QUIET: begin
                nextState = IDLE;
                doneNext  = 1'b1;
              end
              default: nextState = IDLE;
            endcase
          end else begin
            nextHalf = halfCnt + HALF_W'(1);
            // Advance to the next bit only as SCLK falls (odd half -> even half)
            if (state == SHIFT && halfCnt[0]) begin
              nextShift = {shiftReg[FRAME_W-2:0], 1'b0};
            end
          end
        end
      end
    endcase

    sclkNext  = (nextState == SHIFT) && nextHalf[0];
    csnNext   = !(nextState inside {LEAD, SHIFT, TRAIL});
    mosiNext  = (nextState inside {LEAD, SHIFT}) ? nextShift[FRAME_W-1] : 1'b0;
    ldacnNext = (nextState != LATCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      halfCnt <= '0;
      doneQ   <= 1'b0;
      sclkQ   <= 1'b0;
      csnQ    <= 1'b1;
      mosiQ   <= 1'b0;
      ldacnQ  <= 1'b1;
    end else begin
      state   <= nextState;
      halfCnt <= nextHalf;
      doneQ   <= doneNext;
      sclkQ   <= sclkNext;
      csnQ    <= csnNext;
      mosiQ   <= mosiNext;
      ldacnQ  <= ldacnNext;
    end
  end

  // Frame payload: only meaningful while a frame is in flight
  always_ff @(posedge clk) begin
    shiftReg <= nextShift;
  end

  assign bus.ready  = (state == IDLE);
  assign bus.done   = doneQ;
  assign bus.sclk   = sclkQ;
  assign bus.cs_n   = csnQ;
  assign bus.mosi   = mosiQ;
  assign bus.ldac_n = ldacnQ;

endmodule

// File: tb/tb_dac_tx.sv
// Directed bench for dac_tx: one instance at CLK_DIV=2, one at CLK_DIV=1, with a
// per-cycle SPI monitor that decodes frames against a queue of expected words.
module tb_dac_tx;

  logic clk = 1'b0;
  logic reset0, reset1;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   monEn = 1'b0;

  always #5 clk = ~clk;

  dac_tx_if if0 ();
  dac_tx_if if1 ();

  dac_tx #(.CLK_DIV(2)) dut0 (.clk(clk), .reset(reset0), .bus(if0));
  dac_tx #(.CLK_DIV(1)) dut1 (.clk(clk), .reset(reset1), .bus(if1));

  logic [15:0] expQ0[$];
  logic [15:0] expQ1[$];

  int          divOf[2]      = '{2, 1};
  logic        prevSc[2]     = '{1'b0, 1'b0};
  logic        prevCs[2]     = '{1'b1, 1'b1};
  logic        prevMo[2]     = '{1'b0, 1'b0};
  logic        prevLd[2]     = '{1'b1, 1'b1};
  logic [15:0] acc[2]        = '{16'h0, 16'h0};
  int          bitCnt[2]     = '{0, 0};
  int          csFall[2]     = '{0, 0};
  int          csRise[2]     = '{0, 0};
  int          sclkRise[2]   = '{0, 0};
  int          ldacFall[2]   = '{0, 0};
  int          doneCnt[2]    = '{0, 0};
  int          ldacPulses[2] = '{0, 0};
  bit          haveRise[2]   = '{1'b0, 1'b0};
  bit          gapChk[2]     = '{1'b0, 1'b0};
  bit          expectAbort[2] = '{1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic popExp(input int k, output bit ok, output logic [15:0] v);
    ok = 1'b0;
    v  = '0;
    if (k == 0 && expQ0.size() > 0) begin
      v = expQ0.pop_front();
      ok = 1'b1;
    end else if (k == 1 && expQ1.size() > 0) begin
      v = expQ1.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic monitorOne(input int k, input logic sc, input logic cs, input logic mo,
                            input logic ld, input logic dn);
    bit          ok;
    logic [15:0] ev;
    int          d;
    d = divOf[k];
    check($sformatf("proto_mosi_stable%0d", k), {31'b0, (mo !== prevMo[k]) && sc}, 32'd0);
    check($sformatf("proto_ldac_cs%0d", k), {31'b0, !ld && !cs}, 32'd0);
    if (!cs && prevCs[k]) begin
      csFall[k] = cyc;
      bitCnt[k] = 0;
      if (gapChk[k] && haveRise[k])
        check($sformatf("cs_gap%0d", k), cyc - csRise[k], 4 * d + 1);
    end
    if (sc && !prevSc[k]) begin
      if (bitCnt[k] == 0) check($sformatf("first_rise%0d", k), cyc - csFall[k], 3 * d);
      else check($sformatf("sclk_period%0d", k), cyc - sclkRise[k], 2 * d);
      sclkRise[k] = cyc;
      acc[k] = {acc[k][14:0], mo};
      bitCnt[k]++;
    end
    if (cs && !prevCs[k]) begin
      csRise[k]   = cyc;
      haveRise[k] = 1'b1;
      if (expectAbort[k]) begin
        check($sformatf("abort_bits%0d", k), bitCnt[k], 5);
        expectAbort[k] = 1'b0;
      end else begin
        popExp(k, ok, ev);
        check($sformatf("frame_expected%0d", k), {31'b0, ok}, 32'd1);
        check($sformatf("frame_word%0d", k), acc[k], ev);
        check($sformatf("frame_bits%0d", k), bitCnt[k], 16);
        check($sformatf("cs_low%0d", k), cyc - csFall[k], 36 * d);
      end
    end
    if (!ld && prevLd[k]) begin
      ldacFall[k] = cyc;
      ldacPulses[k]++;
      check($sformatf("ldac_at_cs_rise%0d", k), cyc - csRise[k], 0);
    end
    if (ld && !prevLd[k]) check($sformatf("ldac_width%0d", k), cyc - ldacFall[k], 2 * d);
    if (dn) doneCnt[k]++;
    prevSc[k] = sc;
    prevCs[k] = cs;
    prevMo[k] = mo;
    prevLd[k] = ld;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (monEn) begin
      monitorOne(0, if0.sclk, if0.cs_n, if0.mosi, if0.ldac_n, if0.done);
      monitorOne(1, if1.sclk, if1.cs_n, if1.mosi, if1.ldac_n, if1.done);
    end
  endtask

  task automatic waitDone(input int k, input int budget, output int atCyc);
    bit seen;
    seen  = 1'b0;
    atCyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if ((k == 0 && if0.done) || (k == 1 && if1.done)) begin
        seen  = 1'b1;
        atCyc = cyc;
      end
    end
    check($sformatf("done_seen%0d", k), {31'b0, seen}, 32'd1);
  endtask

  int t0, tDone, dc, lp;

  initial begin
    reset0 = 1'b1; reset1 = 1'b1;
    if0.start = 1'b0; if0.data = '0;
    if1.start = 1'b0; if1.data = '0;
    step(); step();
    monEn = 1'b1;
    check("rst_ready", {31'b0, if0.ready}, 32'd1);
    check("rst_done", {31'b0, if0.done}, 32'd0);
    check("rst_sclk", {31'b0, if0.sclk}, 32'd0);
    check("rst_mosi", {31'b0, if0.mosi}, 32'd0);
    check("rst_cs_n", {31'b0, if0.cs_n}, 32'd1);
    check("rst_ldac_n", {31'b0, if0.ldac_n}, 32'd1);
    reset0 = 1'b0; reset1 = 1'b0;
    step();

    // Nominal frame, CLK_DIV=2
    if0.data = 12'hA5C; if0.start = 1'b1; expQ0.push_back(16'h3A5C); t0 = cyc;
    step();
    if0.start = 1'b0;
    check("nom_ready_low", {31'b0, if0.ready}, 32'd0);
    check("nom_cs_low", {31'b0, if0.cs_n}, 32'd0);
    check("nom_lead_mosi", {31'b0, if0.mosi}, 32'd0);
    waitDone(0, 200, tDone);
    check("nom_done_time", tDone - t0, 81);
    check("nom_ready_back", {31'b0, if0.ready}, 32'd1);
    step();
    check("nom_done_pulse", {31'b0, if0.done}, 32'd0);
    check("nom_ldac_pulses", ldacPulses[0], 1);

    // Start while busy, plus data changing after accept
    dc = doneCnt[0];
    if0.data = 12'h5A5; if0.start = 1'b1; expQ0.push_back(16'h35A5);
    step();
    if0.start = 1'b0; if0.data = 12'h0F0;
    for (int i = 0; i < 20; i++) step();
    if0.data = 12'h123; if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    waitDone(0, 200, tDone);
    for (int i = 0; i < 100; i++) step();
    check("busy_one_done", doneCnt[0] - dc, 1);
    check("busy_idle_cs", {31'b0, if0.cs_n}, 32'd1);
    check("busy_queue_empty", expQ0.size(), 0);

    // Back-to-back with start held high
    haveRise[0] = 1'b0; gapChk[0] = 1'b1;
    if0.data = 12'hFFF; if0.start = 1'b1; expQ0.push_back(16'h3FFF);
    step();
    for (int f = 0; f < 2; f++) begin
      waitDone(0, 200, tDone);
      check("b2b_ready_at_done", {31'b0, if0.ready}, 32'd1);
      expQ0.push_back(16'h3FFF);
      step();
      check("b2b_reaccept", {31'b0, if0.ready}, 32'd0);
      check("b2b_cs_low", {31'b0, if0.cs_n}, 32'd0);
    end
    if0.start = 1'b0;
    waitDone(0, 200, tDone);
    gapChk[0] = 1'b0;
    check("b2b_queue_empty", expQ0.size(), 0);

    // Reset abort after 5 bits shifted
    if0.data = 12'h3C3; if0.start = 1'b1; expectAbort[0] = 1'b1;
    step();
    if0.start = 1'b0;
    for (int i = 0; i < 200 && bitCnt[0] < 5; i++) step();
    check("abort_reached5", bitCnt[0], 5);
    dc = doneCnt[0]; lp = ldacPulses[0];
    reset0 = 1'b1;
    step();
    reset0 = 1'b0;
    check("abort_cs_n", {31'b0, if0.cs_n}, 32'd1);
    check("abort_sclk", {31'b0, if0.sclk}, 32'd0);
    check("abort_mosi", {31'b0, if0.mosi}, 32'd0);
    check("abort_ldac_n", {31'b0, if0.ldac_n}, 32'd1);
    check("abort_ready", {31'b0, if0.ready}, 32'd1);
    for (int i = 0; i < 100; i++) step();
    check("abort_no_done", doneCnt[0] - dc, 0);
    check("abort_no_ldac", ldacPulses[0] - lp, 0);

    // Start coincident with reset, CLK_DIV=1
    reset1 = 1'b1; if1.data = 12'hABC; if1.start = 1'b1;
    step();
    reset1 = 1'b0; if1.start = 1'b0;
    step(); step();
    check("rststart_ready", {31'b0, if1.ready}, 32'd1);
    check("rststart_cs_n", {31'b0, if1.cs_n}, 32'd1);

    // Boundary codes, CLK_DIV=1
    if1.data = 12'h000; if1.start = 1'b1; expQ1.push_back(16'h3000); t0 = cyc;
    step();
    if1.start = 1'b0;
    waitDone(1, 100, tDone);
    check("d1_done_time", tDone - t0, 41);
    step();
    if1.data = 12'hFFF; if1.start = 1'b1; expQ1.push_back(16'h3FFF); t0 = cyc;
    step();
    if1.start = 1'b0;
    waitDone(1, 100, tDone);
    check("d1_done_time_fff", tDone - t0, 41);
    for (int i = 0; i < 10; i++) step();
    check("d1_queue_empty", expQ1.size(), 0);
    check("d1_done_count", doneCnt[1], 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dac_tx.md
DAC_TX -- requirements
Module: dac_tx

Interface
REQ-001 Parameter CLK_DIV, default 10, clk cycles per SCLK half-period (>=1; 20 MHz clk gives 1 MHz SCLK).
REQ-002 Parameter BUF, default 0, value of frame bit 14 (VREF buffer select).
REQ-003 Parameter GAIN_1X, default 1, value of frame bit 13 (1 = 1x gain).
REQ-004 Port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port start, input, 1, write request, sampled only while ready=1.
REQ-007 Port data, input, 12, DAC code, MSB first on the wire.
REQ-008 Port ready, output, 1, high when idle and able to accept start.
REQ-009 Port done, output, 1, one-cycle pulse when a frame fully completes.
REQ-010 Port sclk, output, 1, SPI clock, mode 0,0, idle low.
REQ-011 Port cs_n, output, 1, active-low chip select to the DAC.
REQ-012 Port mosi, output, 1, serial data to the DAC.
REQ-013 Port ldac_n, output, 1, active-low latch strobe to the DAC.

Function
REQ-014 Accept SHALL occur on any cycle T with ready=1 and start=1; data is latched into a 16-bit shift register as {0, BUF, GAIN_1X, 1, data}; ready goes low at T+1.
REQ-015 The half-period counter SHALL restart at accept, so all phase boundaries are exact multiples of CLK_DIV cycles after T+1.
REQ-016 States SHALL be IDLE, LEAD, SHIFT, TRAIL, LATCH, QUIET, traversed strictly in that order.
REQ-017 LEAD SHALL last 2 half-periods: cs_n=0 from T+1, sclk=0, mosi=frame bit 15.
REQ-018 SHIFT SHALL last 32 half-periods, forming 16 bits, each sclk low half then sclk high half; mosi SHALL change only when sclk falls, and is stable across each rising edge.
REQ-019 TRAIL SHALL last 2 half-periods with sclk=0 and cs_n=0; cs_n rises at the end of TRAIL.
REQ-020 LATCH SHALL hold cs_n=1 and ldac_n=0 for exactly 2 half-periods; ldac_n SHALL never be low while cs_n=0.
REQ-021 QUIET SHALL last 2 half-periods with all lines idle; on exit, ready=1 and done=1 for one cycle.
REQ-022 ready SHALL therefore return at T+1+40*CLK_DIV, and cs_n SHALL stay low for exactly 36*CLK_DIV cycles.
REQ-023 start while ready=0 SHALL be ignored, with no effect on the frame in flight or on later frames.
REQ-024 Accept SHALL be permitted on the same cycle ready returns high, and done SHALL coincide with that cycle; start held high yields back-to-back frames.
REQ-025 data changes after accept SHALL not affect the frame in flight.
REQ-026 Outside a frame: mosi=0, sclk=0, cs_n=1, ldac_n=1.

Reset
REQ-027 While reset=1: state=IDLE, counters cleared, ready=1, done=0, sclk=0, mosi=0, cs_n=1, ldac_n=1, effective next cycle.
REQ-028 reset mid-frame SHALL abort the frame with no ldac_n pulse and no done pulse.
REQ-029 start coincident with reset=1 SHALL be ignored.

Structure
REQ-030 The shared package/include SHALL hold the frame field positions, the LEAD/TRAIL/LATCH/QUIET half-period counts, and the state encoding.
REQ-031 One sub-module, spi_half_tick, SHALL generate the CLK_DIV half-period strobe with a synchronous restart input; all other logic stays in dac_tx.

Verification
REQ-032 Nominal frame: CLK_DIV=2, data=12'hA5C, start at T -> mosi sampled at 16 sclk rises = 16'h3A5C; cs_n low exactly 72 cycles; ldac_n low 4 cycles after cs_n rises; ready and done at T+81.
REQ-033 Boundary codes: CLK_DIV=1, data=12'h000 then 12'hFFF -> frames 16'h3000 and 16'h3FFF; sclk period 2 cycles.
REQ-034 Start while busy: start with 12'h123 mid-SHIFT -> ignored; in-flight frame unchanged; exactly one done.
REQ-035 Back-to-back: start held high, data=12'hFFF -> second accept on the same cycle as done; cs_n gaps all equal at 4*CLK_DIV+1 cycles.
REQ-036 Reset abort: reset after 5 bits shifted -> next cycle cs_n=1, sclk=0, mosi=0, ldac_n=1, ready=1; no done or ldac_n pulse.
REQ-037 Protocol checker on all tests: mosi never changes while sclk=1, and ldac_n=0 never overlaps cs_n=0.
